// File: rtl/frame_bit_counter_pkg.sv
// Shared types and helpers for the frame bit-position counter.
package frame_bit_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fbc_state_e;

  // A length of zero, or anything beyond the hardware maximum, selects a full frame.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0 || len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Registered rising-edge detector; pulse_o is high for the one cycle where d_i
// is high and was low at the previous clock.
module rise_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/frame_bit_counter.sv
// Bit-position counter for serial frames of programmable length; advances on
// bit ticks and flags the last bit, frame completion and accepted aborts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no frame; waiting for a start_i rising edge
// BUSY    | frame in progress; index advances on each en_i tick
// DONE    | single-cycle completion; may restart straight into BUSY
module frame_bit_counter
  import frame_bit_counter_pkg::*;
#(
  parameter int FRAME_BITS  = 11,
  parameter bit AUTO_RELOAD = 1'b0,
  localparam int IDX_W = $clog2(FRAME_BITS),
  localparam int LEN_W = $clog2(FRAME_BITS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [IDX_W-1:0] bit_idx_o,
  output logic             busy_o,
  output logic             last_bit_o,
  output logic             done_o,
  output logic             aborted_o
);

  localparam int unsigned MAX_LEN = FRAME_BITS;

  fbc_state_e       state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0] len_r, len_d;
  logic             aborted_q, aborted_d;
  logic             start_edge;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] len_clamped;
  logic             at_last;

  rise_edge_detect u_start_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (start_i),
    .pulse_o (start_edge)
  );

  assign len_clamped = LEN_W'(clamp_len(32'(len_i), MAX_LEN));
  assign last_idx    = len_r - LEN_W'(1);
  assign at_last     = (LEN_W'(bit_idx_q) == last_idx);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      len_r     <= LEN_W'(FRAME_BITS);
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      len_r     <= len_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    len_d     = len_r;
    aborted_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bit_idx_d = '0;
        if (start_edge) begin
          state_d = ST_BUSY;
          len_d   = len_clamped;
        end
      end
      ST_BUSY: begin
        // A start edge while busy is deliberately ignored.
        if (en_i) begin
          if (at_last) begin
            state_d   = ST_DONE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        bit_idx_d = '0;
        if (start_edge || (AUTO_RELOAD && start_i)) begin
          state_d = ST_BUSY;
          len_d   = len_clamped;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_idx_d = '0;
      end
    endcase

    // Abort wins over completion and over any restart in the same cycle.
    if (abort_i) begin
      state_d   = ST_IDLE;
      bit_idx_d = '0;
      len_d     = len_r;
      aborted_d = (state_q == ST_BUSY);
    end
  end

  assign bit_idx_o  = bit_idx_q;
  assign busy_o     = (state_q == ST_BUSY);
  assign done_o     = (state_q == ST_DONE);
  assign last_bit_o = busy_o & at_last;
  assign aborted_o  = aborted_q;

endmodule
